// File: rtl/ozixe_lut_cfg_ctrl.sv
// ozixe_lut_cfg_ctrl: streams 16-bit INIT words into one LUT16 INIT memory.
// Optional CRC-16-CCITT trailer check when OZIXE_CFG_CRC_EN is defined.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, lut_sel      load request + target LUT (sampled in IDLE)
//   abort               cancel an in-progress load
//   s_valid/s_ready     config word handshake, s_data word payload
//   mem_we/mem_lut/     INIT memory write port (one cycle after accept)
//   mem_addr/mem_wdata
//   busy, done, err     status: not idle, load-complete pulse, sticky error
//   lut_valid           per-LUT "INIT loaded" flags
module ozixe_lut_cfg_ctrl #(
  parameter  int LUT_COUNT = 16,
  parameter  int NWORDS    = 4096,
  localparam int SELW      = $clog2(LUT_COUNT),
  localparam int AW        = $clog2(NWORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SELW-1:0]      lut_sel,
  input  logic                 abort,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [15:0]          s_data,
  output logic                 mem_we,
  output logic [SELW-1:0]      mem_lut,
  output logic [AW-1:0]        mem_addr,
  output logic [15:0]          mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LUT_COUNT-1:0] lut_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [SELW:0] LC   = (SELW+1)'(LUT_COUNT);
  localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);

  state_t          state;
  state_t          state_n;
  logic [SELW-1:0] lut_q;
  logic [AW-1:0]   cnt;

  logic sel_ok;
  logic idle_go;
  logic idle_bad;
  logic abort_hit;
  logic ld_acc;

`ifdef OZIXE_CFG_CRC_EN
  logic [15:0] crc;
  logic        crc_bad;

  // Bit-serial CRC-16-CCITT, MSB first, no reflection.
  function automatic logic [15:0] crc16_upd(
    input logic [15:0] c,
    input logic [15:0] d
  );
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i])
        r = {r[14:0], 1'b0} ^ 16'h1021;
      else
        r = {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  assign sel_ok = ({1'b0, lut_sel} < LC);
  assign busy   = (state != IDLE);
  assign done   = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    s_ready   = 1'b0;
    idle_go   = 1'b0;
    idle_bad  = 1'b0;
    abort_hit = 1'b0;
    ld_acc    = 1'b0;
`ifdef OZIXE_CFG_CRC_EN
    crc_bad   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start && sel_ok) begin
          idle_go = 1'b1;
          state_n = LOAD;
        end else if (start) begin
          idle_bad = 1'b1;
        end
      end
      LOAD: begin
        s_ready = !abort;
        if (abort) begin
          abort_hit = 1'b1;
          state_n   = IDLE;
        end else if (s_valid) begin
          ld_acc = 1'b1;
          if (cnt == LAST) begin
`ifdef OZIXE_CFG_CRC_EN
            state_n = CHECK;
`else
            state_n = FINISH;
`endif
          end
        end
      end
      CHECK: begin
`ifdef OZIXE_CFG_CRC_EN
        s_ready = !abort;
        if (abort) begin
          abort_hit = 1'b1;
          state_n   = IDLE;
        end else if (s_valid) begin
          // Trailer word is the expected CRC; it is never written.
          if (s_data == crc) begin
            state_n = FINISH;
          end else begin
            crc_bad = 1'b1;
            state_n = IDLE;
          end
        end
`else
        state_n = IDLE;
`endif
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q     <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      lut_valid <= '0;
`ifdef OZIXE_CFG_CRC_EN
      crc       <= 16'hFFFF;
`endif
    end else begin
      if (idle_go) begin
        lut_q              <= lut_sel;
        cnt                <= '0;
        lut_valid[lut_sel] <= 1'b0;
`ifdef OZIXE_CFG_CRC_EN
        crc                <= 16'hFFFF;
`endif
      end
      if (ld_acc) begin
        // Power-of-two depth: natural wrap from LAST to 0.
        cnt <= cnt + 1'b1;
`ifdef OZIXE_CFG_CRC_EN
        crc <= crc16_upd(crc, s_data);
`endif
      end
      if (idle_go)
        err <= 1'b0;
      else if (idle_bad || abort_hit)
        err <= 1'b1;
`ifdef OZIXE_CFG_CRC_EN
      else if (crc_bad)
        err <= 1'b1;
`endif
      if (state == FINISH)
        lut_valid[lut_q] <= 1'b1;
    end
  end

  // Write port: registered one cycle behind acceptance, holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_lut   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= ld_acc;
      if (ld_acc) begin
        mem_lut   <= lut_q;
        mem_addr  <= cnt;
        mem_wdata <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_ozixe_lut_cfg_ctrl.sv
// Directed bench for ozixe_lut_cfg_ctrl (LUT_COUNT=12, NWORDS=4).
// Writes/accepts are logged on the falling edge and compared per test.
module tb_ozixe_lut_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  lut_sel;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        mem_we;
  logic [3:0]  mem_lut;
  logic [1:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] lut_valid;

  int nvec = 0;
  int nerr = 0;

  int cyc = 0;
  int done_cnt = 0;
  int busy_lo = 0;
  int busy_hi = 0;
  int          acc_cyc[$];
  int          wr_cyc[$];
  logic [1:0]  wr_addr[$];
  logic [3:0]  wr_lut[$];
  logic [15:0] wr_data[$];

  logic [15:0] wv[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  ozixe_lut_cfg_ctrl #(
    .LUT_COUNT(12),
    .NWORDS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .lut_sel(lut_sel),
    .abort(abort),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .mem_we(mem_we),
    .mem_lut(mem_lut),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .busy(busy),
    .done(done),
    .err(err),
    .lut_valid(lut_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_valid && s_ready) acc_cyc.push_back(cyc);
    if (mem_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(mem_addr);
      wr_lut.push_back(mem_lut);
      wr_data.push_back(mem_wdata);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_hi <= busy_hi + 1;
    else busy_lo <= busy_lo + 1;
  end

  function automatic logic [15:0] crc_model(input logic [15:0] w[4]);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int k = 0; k < 4; k++)
      for (int i = 15; i >= 0; i--)
        r = (r[15] ^ w[k][i]) ? ({r[14:0], 1'b0} ^ 16'h1021)
                              : {r[14:0], 1'b0};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [3:0] sel);
    start = 1'b1;
    lut_sel = sel;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input int gap);
    bit got;
    got = 0;
    s_valid = 1'b1;
    s_data = d;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = s_ready;
      step();
    end
    s_valid = 1'b0;
    nvec++;
    if (!got) begin
      nerr++;
      $display("FAIL send_word timeout: s_ready=0 for %h, want 1", d);
    end
    repeat (gap) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    lut_sel = 4'd3;
    abort = 1'b0;
    s_valid = 1'b1;
    s_data = 16'hABCD;
    #3;
    nvec++;
    if ({s_ready, mem_we, busy, done, err} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_ctl: rdy/we/busy/done/err=%b want 00000",
               {s_ready, mem_we, busy, done, err});
    end
    nvec++;
    if ({mem_lut, mem_addr, mem_wdata, lut_valid} !== 34'b0) begin
      nerr++;
      $display("FAIL reset_data: lut=%h addr=%h wd=%h lv=%h want 0",
               mem_lut, mem_addr, mem_wdata, lut_valid);
    end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    step();
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int w0;
    int a0;
    int d0;
    w0 = wr_cyc.size();
    a0 = acc_cyc.size();
    d0 = done_cnt;
    start_load(4'd3);
    for (int i = 0; i < 4; i++) send_word(wv[i], 0);
`ifdef OZIXE_CFG_CRC_EN
    send_word(crc_model(wv), 0);
`endif
    repeat (3) step();
    nvec++;
    if (wr_cyc.size() - w0 !== 4) begin
      nerr++;
      $display("FAIL basic_nwr: got %0d want 4", wr_cyc.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (wr_addr[w0+i] !== 2'(i) || wr_lut[w0+i] !== 4'd3 ||
            wr_data[w0+i] !== wv[i] ||
            wr_cyc[w0+i] !== acc_cyc[a0+i] + 1) begin
          nerr++;
          $display("FAIL basic_wr%0d: a=%0d l=%0d d=%h dly=%0d want a=%0d l=3 d=%h dly=1",
                   i, wr_addr[w0+i], wr_lut[w0+i], wr_data[w0+i],
                   wr_cyc[w0+i] - acc_cyc[a0+i], i, wv[i]);
        end
      end
    end
    nvec++;
    if (done_cnt - d0 !== 1) begin
      nerr++;
      $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0);
    end
    nvec++;
    if (lut_valid !== 12'h008 || err !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL basic_status: lv=%h err=%b busy=%b want 008 0 0",
               lut_valid, err, busy);
    end
  endtask

  task automatic test_gaps();
    int w0;
    int a0;
    int d0;
    int b0;
    w0 = wr_cyc.size();
    a0 = acc_cyc.size();
    d0 = done_cnt;
    start_load(4'd3);
    b0 = busy_lo;
    nvec++;
    if (lut_valid !== 12'h000) begin
      nerr++;
      $display("FAIL gaps_lv_clear: got %h want 000", lut_valid);
    end
    send_word(wv[0], 5);
    // A start request mid-load must be ignored.
    start = 1'b1;
    lut_sel = 4'd5;
    step();
    start = 1'b0;
    send_word(wv[1], 5);
    send_word(wv[2], 5);
`ifdef OZIXE_CFG_CRC_EN
    send_word(wv[3], 5);
    send_word(crc_model(wv), 0);
`else
    send_word(wv[3], 0);
`endif
    nvec++;
    if (busy_lo - b0 !== 0) begin
      nerr++;
      $display("FAIL gaps_busy: busy low %0d cycles want 0", busy_lo - b0);
    end
    repeat (3) step();
    nvec++;
    if (wr_cyc.size() - w0 !== 4) begin
      nerr++;
      $display("FAIL gaps_nwr: got %0d want 4", wr_cyc.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (wr_addr[w0+i] !== 2'(i) || wr_lut[w0+i] !== 4'd3 ||
            wr_data[w0+i] !== wv[i] ||
            wr_cyc[w0+i] !== acc_cyc[a0+i] + 1) begin
          nerr++;
          $display("FAIL gaps_wr%0d: a=%0d l=%0d d=%h dly=%0d want a=%0d l=3 d=%h dly=1",
                   i, wr_addr[w0+i], wr_lut[w0+i], wr_data[w0+i],
                   wr_cyc[w0+i] - acc_cyc[a0+i], i, wv[i]);
        end
      end
    end
    nvec++;
    if (done_cnt - d0 !== 1 || lut_valid !== 12'h008) begin
      nerr++;
      $display("FAIL gaps_done: pulses=%0d lv=%h want 1 008",
               done_cnt - d0, lut_valid);
    end
  endtask

  task automatic test_abort();
    int w0;
    int a0;
    int d0;
    w0 = wr_cyc.size();
    a0 = acc_cyc.size();
    d0 = done_cnt;
    start_load(4'd3);
    send_word(wv[0], 0);
    send_word(wv[1], 0);
    s_valid = 1'b1;
    s_data = wv[2];
    abort = 1'b1;
    @(negedge clk);
    nvec++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL abort_rdy: s_ready=%b busy=%b want 0 1", s_ready, busy);
    end
    step();
    abort = 1'b0;
    s_valid = 1'b0;
    nvec++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      nerr++;
      $display("FAIL abort_idle: busy=%b err=%b want 0 1", busy, err);
    end
    repeat (3) step();
    nvec++;
    if (wr_cyc.size() - w0 !== 2 || acc_cyc.size() - a0 !== 2) begin
      nerr++;
      $display("FAIL abort_nwr: writes=%0d accepts=%0d want 2 2",
               wr_cyc.size() - w0, acc_cyc.size() - a0);
    end
    nvec++;
    if (done_cnt - d0 !== 0 || lut_valid[3] !== 1'b0) begin
      nerr++;
      $display("FAIL abort_done: pulses=%0d lv3=%b want 0 0",
               done_cnt - d0, lut_valid[3]);
    end
  endtask

  task automatic test_bad_index();
    int w0;
    int h0;
    w0 = wr_cyc.size();
    step();
    h0 = busy_hi;
    start_load(4'd13);
    nvec++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL bad13: err=%b busy=%b want 1 0", err, busy);
    end
    start_load(4'd12);
    nvec++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL bad12: err=%b busy=%b want 1 0", err, busy);
    end
    repeat (3) step();
    nvec++;
    if (busy_hi - h0 !== 0 || wr_cyc.size() - w0 !== 0 ||
        lut_valid !== 12'h000) begin
      nerr++;
      $display("FAIL bad_quiet: busy_cyc=%0d writes=%0d lv=%h want 0 0 000",
               busy_hi - h0, wr_cyc.size() - w0, lut_valid);
    end
  endtask

  task automatic test_async_reset();
    int w0;
    int d0;
    w0 = wr_cyc.size();
    d0 = done_cnt;
    start_load(4'd3);
    nvec++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL ar_start: err=%b busy=%b want 0 1", err, busy);
    end
    send_word(wv[0], 0);
    #6;
    nvec++;
    if (mem_we !== 1'b1 || mem_wdata !== 16'h1111) begin
      nerr++;
      $display("FAIL ar_pre: we=%b wd=%h want 1 1111", mem_we, mem_wdata);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({s_ready, mem_we, busy, done, err, mem_lut, mem_addr,
         mem_wdata, lut_valid} !== 39'b0) begin
      nerr++;
      $display("FAIL ar_zero: rdy=%b we=%b busy=%b done=%b err=%b lut=%h addr=%h wd=%h lv=%h want all 0",
               s_ready, mem_we, busy, done, err, mem_lut, mem_addr,
               mem_wdata, lut_valid);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    s_valid = 1'b1;
    s_data = 16'h5555;
    repeat (4) step();
    s_valid = 1'b0;
    repeat (2) step();
    nvec++;
    if (wr_cyc.size() - w0 !== 1 || done_cnt - d0 !== 0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL ar_after: writes=%0d pulses=%0d busy=%b want 1 0 0",
               wr_cyc.size() - w0, done_cnt - d0, busy);
    end
  endtask

`ifdef OZIXE_CFG_CRC_EN
  task automatic test_crc();
    logic [15:0] z[4];
    logic [15:0] c;
    int w0;
    int d0;
    z = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    c = crc_model(z);
    w0 = wr_cyc.size();
    d0 = done_cnt;
    start_load(4'd3);
    for (int i = 0; i < 4; i++) send_word(z[i], 0);
    send_word(c, 0);
    repeat (3) step();
    nvec++;
    if (done_cnt - d0 !== 1 || lut_valid[3] !== 1'b1 || err !== 1'b0 ||
        wr_cyc.size() - w0 !== 4) begin
      nerr++;
      $display("FAIL crc_good: pulses=%0d lv3=%b err=%b writes=%0d want 1 1 0 4",
               done_cnt - d0, lut_valid[3], err, wr_cyc.size() - w0);
    end
    w0 = wr_cyc.size();
    d0 = done_cnt;
    start_load(4'd3);
    for (int i = 0; i < 4; i++) send_word(z[i], 0);
    send_word(c ^ 16'h0001, 0);
    repeat (3) step();
    nvec++;
    if (done_cnt - d0 !== 0 || lut_valid[3] !== 1'b0 || err !== 1'b1 ||
        wr_cyc.size() - w0 !== 4 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL crc_bad: pulses=%0d lv3=%b err=%b writes=%0d busy=%b want 0 0 1 4 0",
               done_cnt - d0, lut_valid[3], err, wr_cyc.size() - w0, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_bad_index();
    test_async_reset();
`ifdef OZIXE_CFG_CRC_EN
    test_crc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
